scarv_cop_issue: RTL and testbench

Instruction issue controller for the SCARV coprocessor. It accepts one ISE instruction at a time from the host CPU and drives the held encoding into the instruction decoder. It then dispatches to the functional unit selected by the decoded class, and sequences coprocessor-register (CPR) writeback through a single write port, splitting multi-precision two-destination results into two writes. Finally it returns a status and optional GPR result to the CPU.

---
 rtl/scarv_cop_issue.sv | 250 +++++++++++++++++++++++++
 tb/tb_scarv_cop_issue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_issue.sv
// SCARV coprocessor issue controller: holds one ISE instruction, dispatches it to a
// functional unit, sequences CPR writeback (split into two writes for wide results) and responds.
module scarv_cop_issue #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ack,
  output logic [2:0]  cpu_rsp_status,
  output logic        cpu_rsp_wen,
  output logic [4:0]  cpu_rsp_rd,
  output logic [31:0] cpu_rsp_wdata,
  output logic [31:0] id_encoded,
  input  logic        id_exception,
  input  logic [2:0]  id_class,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_crd,
  input  logic [3:0]  id_crd1,
  input  logic [3:0]  id_crd2,
  output logic [31:0] fu_rs1,
  output logic [7:0]  fu_valid,
  output logic        fu_flush,
  input  logic        fu_done,
  input  logic        fu_error,
  input  logic        fu_gpr_wen,
  input  logic        fu_cpr_wen,
  input  logic        fu_wide,
  input  logic [31:0] fu_rdata_lo,
  input  logic [31:0] fu_rdata_hi,
  output logic        cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [31:0] cpr_wdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [2:0] ST_OK  = 3'd0;
  localparam logic [2:0] ST_ILL = 3'd1;
  localparam logic [2:0] ST_FU  = 3'd2;
  localparam logic [2:0] ST_TMO = 3'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    WB_LO   = 3'd3,
    WB_HI   = 3'd4,
    RESPOND = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   enc_q, enc_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic [3:0]    crd_q, crd_d;
  logic [3:0]    crd1_q, crd1_d;
  logic [3:0]    crd2_q, crd2_d;
  logic          gpr_wen_q, gpr_wen_d;
  logic          wide_q, wide_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_q, hi_d;
  logic [2:0]    status_q, status_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_wen_q, rsp_wen_d;

  // Next-state and latched-field computation for the issue sequence
  always_comb begin
    state_d     = state_q;
    enc_d       = enc_q;
    rs1_d       = rs1_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    crd_d       = crd_q;
    crd1_d      = crd1_q;
    crd2_d      = crd2_q;
    gpr_wen_d   = gpr_wen_q;
    wide_d      = wide_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    status_d    = status_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wen_d   = rsp_wen_q;
    case (state_q)
      IDLE: begin
        if (cpu_insn_req) begin
          enc_d   = cpu_insn_enc;
          rs1_d   = cpu_rs1;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (id_exception) begin
          status_d    = ST_ILL;
          rsp_valid_d = 1'b1;
          rsp_wen_d   = 1'b0;
          state_d     = RESPOND;
        end else begin
          cnt_d   = CNT_ZERO;
          rd_d    = id_rd;
          crd_d   = id_crd;
          crd1_d  = id_crd1;
          crd2_d  = id_crd2;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Completion takes priority over the timeout in the same cycle
        if (fu_done) begin
          gpr_wen_d = fu_gpr_wen & ~fu_error;
          wide_d    = fu_wide & ~fu_error;
          lo_d      = fu_rdata_lo;
          hi_d      = fu_rdata_hi;
          if (fu_error) begin
            status_d    = ST_FU;
            rsp_valid_d = 1'b1;
            rsp_wen_d   = 1'b0;
            state_d     = RESPOND;
          end else if (fu_cpr_wen) begin
            status_d = ST_OK;
            state_d  = WB_LO;
          end else begin
            status_d    = ST_OK;
            rsp_valid_d = 1'b1;
            rsp_wen_d   = fu_gpr_wen;
            state_d     = RESPOND;
          end
        end else if (cnt_q == CNT_LAST) begin
          status_d    = ST_TMO;
          rsp_valid_d = 1'b1;
          rsp_wen_d   = 1'b0;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WB_LO: begin
        if (wide_q) begin
          state_d = WB_HI;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_wen_d   = gpr_wen_q;
          state_d     = RESPOND;
        end
      end
      WB_HI: begin
        rsp_valid_d = 1'b1;
        rsp_wen_d   = gpr_wen_q;
        state_d     = RESPOND;
      end
      RESPOND: begin
        if (cpu_rsp_ack) begin
          rsp_valid_d = 1'b0;
          rsp_wen_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESPOND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-field registers
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= IDLE;
      enc_q       <= 32'h0000_0000;
      rs1_q       <= 32'h0000_0000;
      cnt_q       <= CNT_ZERO;
      rd_q        <= 5'd0;
      crd_q       <= 4'd0;
      crd1_q      <= 4'd0;
      crd2_q      <= 4'd0;
      gpr_wen_q   <= 1'b0;
      wide_q      <= 1'b0;
      lo_q        <= 32'h0000_0000;
      hi_q        <= 32'h0000_0000;
      status_q    <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      rs1_q       <= rs1_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      crd_q       <= crd_d;
      crd1_q      <= crd1_d;
      crd2_q      <= crd2_d;
      gpr_wen_q   <= gpr_wen_d;
      wide_q      <= wide_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      status_q    <= status_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wen_q   <= rsp_wen_d;
    end
  end

  // Dispatch, flush and CPR write port decoded from state plus latched data
  always_comb begin
    cpu_insn_ack = (state_q == IDLE);
    fu_flush     = (state_q == EXEC) && !fu_done && (cnt_q == CNT_LAST);
    fu_valid     = 8'h00;
    if ((state_q == DECODE) && !id_exception) begin
      fu_valid[id_class] = 1'b1;
    end else begin
      fu_valid = 8'h00;
    end
    case (state_q)
      WB_LO: begin
        cpr_wen   = 1'b1;
        cpr_waddr = wide_q ? crd1_q : crd_q;
        cpr_wdata = lo_q;
      end
      WB_HI: begin
        cpr_wen   = 1'b1;
        cpr_waddr = crd2_q;
        cpr_wdata = hi_q;
      end
      default: begin
        cpr_wen   = 1'b0;
        cpr_waddr = 4'd0;
        cpr_wdata = 32'h0000_0000;
      end
    endcase
  end

  assign id_encoded     = enc_q;
  assign fu_rs1         = rs1_q;
  assign cpu_rsp_valid  = rsp_valid_q;
  assign cpu_rsp_status = status_q;
  assign cpu_rsp_wen    = rsp_wen_q;
  assign cpu_rsp_rd     = rd_q;
  assign cpu_rsp_wdata  = lo_q;

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Randomized self-checking bench for scarv_cop_issue: each transaction's cycle schedule
// and output values are derived from the instruction's outcome rules.
module tb_scarv_cop_issue;
  localparam int TO = 4;

  logic        g_clk, g_reset;
  logic        cpu_insn_req, cpu_insn_ack;
  logic [31:0] cpu_insn_enc, cpu_rs1;
  logic        cpu_rsp_valid, cpu_rsp_ack;
  logic [2:0]  cpu_rsp_status;
  logic        cpu_rsp_wen;
  logic [4:0]  cpu_rsp_rd;
  logic [31:0] cpu_rsp_wdata, id_encoded;
  logic        id_exception;
  logic [2:0]  id_class;
  logic [4:0]  id_rd;
  logic [3:0]  id_crd, id_crd1, id_crd2;
  logic [31:0] fu_rs1;
  logic [7:0]  fu_valid;
  logic        fu_flush, fu_done, fu_error, fu_gpr_wen, fu_cpr_wen, fu_wide;
  logic [31:0] fu_rdata_lo, fu_rdata_hi;
  logic        cpr_wen;
  logic [3:0]  cpr_waddr;
  logic [31:0] cpr_wdata;

  scarv_cop_issue #(.TIMEOUT_CYCLES(TO)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ack(cpu_rsp_ack),
    .cpu_rsp_status(cpu_rsp_status), .cpu_rsp_wen(cpu_rsp_wen),
    .cpu_rsp_rd(cpu_rsp_rd), .cpu_rsp_wdata(cpu_rsp_wdata),
    .id_encoded(id_encoded), .id_exception(id_exception), .id_class(id_class),
    .id_rd(id_rd), .id_crd(id_crd), .id_crd1(id_crd1), .id_crd2(id_crd2),
    .fu_rs1(fu_rs1), .fu_valid(fu_valid), .fu_flush(fu_flush),
    .fu_done(fu_done), .fu_error(fu_error), .fu_gpr_wen(fu_gpr_wen),
    .fu_cpr_wen(fu_cpr_wen), .fu_wide(fu_wide),
    .fu_rdata_lo(fu_rdata_lo), .fu_rdata_hi(fu_rdata_hi),
    .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr), .cpr_wdata(cpr_wdata)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  typedef struct {
    logic [31:0] enc, rs1, lo, hi;
    bit          exc, err, gw, cw, wide, hold, spur;
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [3:0]  crd, crd1, crd2;
    int          d, ackd, rst_c;
  } txn_t;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t.enc = 32'h0; t.rs1 = 32'h0; t.lo = 32'h0; t.hi = 32'h0;
    t.exc = 1'b0; t.err = 1'b0; t.gw = 1'b0; t.cw = 1'b0; t.wide = 1'b0;
    t.hold = 1'b0; t.spur = 1'b0;
    t.cls = 3'd0; t.rd = 5'd0; t.crd = 4'd0; t.crd1 = 4'd0; t.crd2 = 4'd0;
    t.d = 0; t.ackd = 0; t.rst_c = -1;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t = base_txn();
    t.enc = $urandom; t.rs1 = $urandom; t.lo = $urandom; t.hi = $urandom;
    t.exc = ($urandom_range(0, 7) == 0);
    t.err = ($urandom_range(0, 5) == 0);
    t.gw = 1'($urandom); t.cw = 1'($urandom); t.wide = 1'($urandom);
    t.hold = 1'($urandom); t.spur = 1'($urandom);
    t.cls = 3'($urandom); t.rd = 5'($urandom);
    t.crd = 4'($urandom); t.crd1 = 4'($urandom); t.crd2 = 4'($urandom);
    t.d = $urandom_range(0, TO + 1);
    t.ackd = $urandom_range(0, 3);
    return t;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " ack"}, cpu_insn_ack, 1'b1);
    check_eq({tag, " rsp_valid"}, cpu_rsp_valid, 1'b0);
    check_eq({tag, " status"}, cpu_rsp_status, 3'd0);
    check_eq({tag, " rsp_wen"}, cpu_rsp_wen, 1'b0);
    check_eq({tag, " rd"}, cpu_rsp_rd, 5'd0);
    check_eq({tag, " wdata"}, cpu_rsp_wdata, 32'h0);
    check_eq({tag, " id_encoded"}, id_encoded, 32'h0);
    check_eq({tag, " fu_rs1"}, fu_rs1, 32'h0);
    check_eq({tag, " fu_valid"}, fu_valid, 8'h00);
    check_eq({tag, " flush"}, fu_flush, 1'b0);
    check_eq({tag, " cpr_wen"}, cpr_wen, 1'b0);
  endtask

  // Runs one instruction from the acceptance cycle (c=0) until the response is acknowledged.
  task automatic run_insn(input txn_t t, input string name);
    int cd, rsp_c, last;
    logic [2:0] st;
    bit tmo, wr_lo, in_exec, ew;
    logic [3:0] ea;
    logic [31:0] ed;
    tmo = !t.exc && (t.d >= TO);
    cd = 2 + t.d;
    if (t.exc)       begin rsp_c = 2;      st = 3'd1; end
    else if (tmo)    begin rsp_c = 2 + TO; st = 3'd3; end
    else if (t.err)  begin rsp_c = cd + 1; st = 3'd2; end
    else if (t.cw)   begin rsp_c = cd + (t.wide ? 3 : 2); st = 3'd0; end
    else             begin rsp_c = cd + 1; st = 3'd0; end
    wr_lo = !t.exc && !tmo && !t.err && t.cw;
    last = rsp_c + t.ackd;
    for (int c = 0; c <= last; c++) begin
      in_exec = !t.exc && (c >= 2) && (tmo ? (c <= 1 + TO) : (c <= cd));
      cpu_insn_req = (c == 0) ? 1'b1 : t.hold;
      cpu_insn_enc = (c == 0) ? t.enc : $urandom;
      cpu_rs1      = (c == 0) ? t.rs1 : $urandom;
      id_exception = (c == 1) ? t.exc : 1'($urandom);
      id_class     = (c == 1) ? t.cls : 3'($urandom);
      id_rd        = (c == 1) ? t.rd : 5'($urandom);
      id_crd       = (c == 1) ? t.crd : 4'($urandom);
      id_crd1      = (c == 1) ? t.crd1 : 4'($urandom);
      id_crd2      = (c == 1) ? t.crd2 : 4'($urandom);
      cpu_rsp_ack  = (c == last);
      if (in_exec && !tmo && c == cd) begin
        fu_done = 1'b1; fu_error = t.err; fu_gpr_wen = t.gw; fu_cpr_wen = t.cw;
        fu_wide = t.wide; fu_rdata_lo = t.lo; fu_rdata_hi = t.hi;
      end else if (in_exec) begin
        fu_done = 1'b0; fu_error = 1'($urandom); fu_gpr_wen = 1'($urandom);
        fu_cpr_wen = 1'($urandom); fu_wide = 1'($urandom);
        fu_rdata_lo = $urandom; fu_rdata_hi = $urandom;
      end else begin
        fu_done = t.spur; fu_error = 1'b0; fu_gpr_wen = 1'b1; fu_cpr_wen = 1'b1;
        fu_wide = 1'b1; fu_rdata_lo = $urandom; fu_rdata_hi = $urandom;
      end
      if (c == t.rst_c) begin
        cpu_insn_req = 1'b0; fu_done = 1'b0; cpu_rsp_ack = 1'b0;
        g_reset = 1'b1;
        #1;
        check_reset_outputs({name, " midrst"});
        @(negedge g_clk);
        check_eq({name, " midrst held cpr_wen"}, cpr_wen, 1'b0);
        g_reset = 1'b0;
        @(negedge g_clk);
        return;
      end
      #1;
      check_eq($sformatf("%s c%0d ack", name, c), cpu_insn_ack, (c == 0));
      check_eq($sformatf("%s c%0d fu_valid", name, c), fu_valid,
               (c == 1 && !t.exc) ? (32'h1 << t.cls) : 32'h0);
      check_eq($sformatf("%s c%0d flush", name, c), fu_flush, (tmo && c == 1 + TO));
      ew = 1'b0; ea = 4'd0; ed = 32'h0;
      if (wr_lo && c == cd + 1) begin
        ew = 1'b1; ea = t.wide ? t.crd1 : t.crd; ed = t.lo;
      end else if (wr_lo && t.wide && c == cd + 2) begin
        ew = 1'b1; ea = t.crd2; ed = t.hi;
      end else begin
        ew = 1'b0;
      end
      check_eq($sformatf("%s c%0d cpr_wen", name, c), cpr_wen, ew);
      if (ew) begin
        check_eq($sformatf("%s c%0d cpr_waddr", name, c), cpr_waddr, ea);
        check_eq($sformatf("%s c%0d cpr_wdata", name, c), cpr_wdata, ed);
      end
      if (c >= 1) begin
        check_eq($sformatf("%s c%0d id_encoded", name, c), id_encoded, t.enc);
        check_eq($sformatf("%s c%0d fu_rs1", name, c), fu_rs1, t.rs1);
      end
      check_eq($sformatf("%s c%0d rsp_valid", name, c), cpu_rsp_valid, (c >= rsp_c));
      if (c >= rsp_c) begin
        check_eq($sformatf("%s c%0d status", name, c), cpu_rsp_status, st);
        check_eq($sformatf("%s c%0d rsp_wen", name, c), cpu_rsp_wen, (st == 3'd0) && t.gw);
        if (!t.exc)
          check_eq($sformatf("%s c%0d rsp_rd", name, c), cpu_rsp_rd, t.rd);
        if (st == 3'd0 || st == 3'd2)
          check_eq($sformatf("%s c%0d rsp_wdata", name, c), cpu_rsp_wdata, t.lo);
      end
      @(negedge g_clk);
    end
  endtask

  initial begin
    txn_t t;
    g_reset = 1'b1;
    cpu_insn_req = 1'b0; cpu_insn_enc = 32'h0; cpu_rs1 = 32'h0; cpu_rsp_ack = 1'b0;
    id_exception = 1'b0; id_class = 3'd0; id_rd = 5'd0;
    id_crd = 4'd0; id_crd1 = 4'd0; id_crd2 = 4'd0;
    fu_done = 1'b0; fu_error = 1'b0; fu_gpr_wen = 1'b0; fu_cpr_wen = 1'b0; fu_wide = 1'b0;
    fu_rdata_lo = 32'h0; fu_rdata_hi = 32'h0;
    repeat (2) @(negedge g_clk);
    #1;
    check_reset_outputs("reset");
    g_reset = 1'b0;
    @(negedge g_clk);

    t = base_txn(); t.enc = 32'hA5A5_0001; t.rs1 = 32'h1234_5678; t.exc = 1'b1;
    t.gw = 1'b1; t.ackd = 2;
    run_insn(t, "illegal");

    t = base_txn(); t.enc = 32'h0000_3003; t.rs1 = 32'hCAFE_0000; t.cls = 3'd3;
    t.d = 2; t.gw = 1'b1; t.lo = 32'hDEAD_BEEF; t.rd = 5'd7; t.ackd = 1;
    run_insn(t, "gpr");

    t = base_txn(); t.enc = 32'h0000_5005; t.cls = 3'd5; t.crd = 4'd9; t.crd1 = 4'd4;
    t.crd2 = 4'd5; t.d = 0; t.cw = 1'b1; t.wide = 1'b1;
    t.lo = 32'h1111_1111; t.hi = 32'h2222_2222; t.spur = 1'b1;
    run_insn(t, "wide");

    t = base_txn(); t.enc = 32'h0000_7007; t.cls = 3'd1; t.d = TO; t.gw = 1'b1;
    t.spur = 1'b1; t.ackd = 3;
    run_insn(t, "timeout");

    t = base_txn(); t.enc = 32'h0000_8008; t.cls = 3'd2; t.d = TO - 1; t.cw = 1'b1;
    t.crd = 4'd3; t.lo = 32'h3333_4444; t.gw = 1'b1; t.rd = 5'd12;
    run_insn(t, "done_at_limit");

    t = base_txn(); t.enc = 32'h0000_9009; t.rs1 = 32'h9; t.cls = 3'd6; t.crd1 = 4'd4;
    t.crd2 = 4'd5; t.d = 1; t.cw = 1'b1; t.wide = 1'b1;
    t.lo = 32'h5555_5555; t.hi = 32'h6666_6666; t.rst_c = 4;
    run_insn(t, "rst_wb");

    t = base_txn(); t.enc = 32'h0000_A00A; t.rs1 = 32'hA; t.cls = 3'd0; t.d = 1;
    t.cw = 1'b1; t.crd = 4'd8; t.lo = 32'h7777_8888;
    run_insn(t, "after_rst");

    t = base_txn(); t.enc = 32'h0000_B00B; t.cls = 3'd4; t.d = 1; t.err = 1'b1;
    t.cw = 1'b1; t.wide = 1'b1; t.gw = 1'b1; t.lo = 32'hE000_0001; t.rd = 5'd3;
    t.hold = 1'b1; t.ackd = 1;
    run_insn(t, "fu_err");

    t = base_txn(); t.enc = 32'h0000_C00C; t.cls = 3'd7; t.d = 0; t.gw = 1'b1;
    t.lo = 32'h0BAD_F00D; t.rd = 5'd31; t.hold = 1'b1;
    run_insn(t, "b2b");

    for (int i = 0; i < 150; i++) begin
      run_insn(rand_txn(), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
